dp_vpi_bridge_mc: RTL
=====================

Name: dp_vpi_bridge_mc

Overview:
Multi-channel successor of the DP<->VPI two-FIFO pipe. NUM_CH independent DP requesters each own a request FIFO and a response FIFO. Request FIFOs are merged by a round-robin arbiter into one registered VPI-side request stage that carries a channel tag. VPI responses are steered back to the tagged channel's response FIFO. All FIFOs are first-word-fall-through, hold exactly 2^AW entries, and report almost-full and sticky overflow/underflow errors.

Parameters:
NUM_CH, 4, number of DP channels (power of two, >=2)
CH_BITS, 2, log2(NUM_CH)
DATA_WIDTH, 32, data field width
ADDR_WIDTH, 31, address field width
TID_WIDTH, 16, transaction ID width
REQ_AW, 2, request FIFO address bits; depth 2^REQ_AW
RSP_AW, 2, response FIFO address bits; depth 2^RSP_AW
AFULL_LVL, 3, almost-full threshold, valid range 1..depth
REQ_W, TID_WIDTH+1+ADDR_WIDTH+DATA_WIDTH, request word {tid, flag, addr, data}
RSP_W, TID_WIDTH+DATA_WIDTH, response word {tid, data}

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
dp_req_data  in  NUM_CH*REQ_W  per-channel request word; channel i occupies bits [i*REQ_W +: REQ_W]
dp_req_wr  in  NUM_CH  per-channel request push
dp_req_full  out  NUM_CH  request FIFO count == depth
dp_req_afull  out  NUM_CH  request FIFO count >= AFULL_LVL
vpi_req_data  out  REQ_W  arbitrated request
vpi_req_ch  out  CH_BITS  source channel of vpi_req_data
vpi_req_valid  out  1  output stage holds a request
vpi_req_rd  in  1  pop output stage
vpi_rsp_data  in  RSP_W  response word
vpi_rsp_ch  in  CH_BITS  destination channel
vpi_rsp_wr  in  1  response push
vpi_rsp_full  out  NUM_CH  response FIFO count == depth
dp_rsp_data  out  NUM_CH*RSP_W  per-channel FWFT head
dp_rsp_valid  out  NUM_CH  response FIFO non-empty
dp_rsp_rd  in  NUM_CH  per-channel response pop
err_ovf  out  2*NUM_CH  sticky overflow; [NUM_CH-1:0] request FIFOs, upper half response FIFOs
err_unf  out  NUM_CH+1  sticky underflow; [NUM_CH-1:0] response pops, [NUM_CH] vpi_req_rd

Behaviour:
- Reset (rst=0, asynchronous): pointers, counts, output stage, last_grant (= NUM_CH-1) and error bits cleared. All outputs 0, including data buses. Reset mid-traffic discards all contents; the first cycle after release is identical to power-up.
- FIFO: count register 0..depth (AW+1 bits); pointers wrap modulo depth. full = (count == depth). Full is exact: no DEPTH-1 early full.
- Push while full: word dropped, state unchanged, matching err_ovf bit set. This holds even if a pop occurs in the same cycle, because full is judged on registered state.
- Pop while empty: ignored, matching err_unf bit set. A simultaneous push is still accepted.
- Simultaneous push and pop when neither full nor empty: both take effect, count unchanged.
- FWFT: head data and valid are visible the cycle after the push edge.
- Request arbitration:
  - The output stage loads when it is empty, or when it is valid and vpi_req_rd=1 in the same cycle (back-to-back, no bubble).
  - The granted channel is the first non-empty request FIFO searching last_grant+1, +2, ... (mod NUM_CH).
  - On load, the head is popped from the granted channel and last_grant is updated.
  - Latency: a push at edge t into an idle bridge gives vpi_req_valid=1 after edge t+1.
  - The output stage holds data and ch until popped.
- Response steering: when vpi_rsp_wr=1, the word is pushed to FIFO vpi_rsp_ch, subject to the full/overflow rule. dp_rsp_valid[i] = !empty[i].
- Error bits clear only on reset.

Test Plan:
- Reset sanity: hold rst=0, then release -> all outputs 0, dp_rsp_valid=0, vpi_req_valid=0, err_* = 0.
- Single request: ch2 pushes tid=0x0005, flag=1, addr=0x10, data=0xA5A5A5A5 at edge t -> vpi_req_valid=1 with vpi_req_ch=2 and the matching word after edge t+1. vpi_req_rd pop -> valid=0 next cycle.
- Fairness: all 4 channels each hold 2 requests, vpi_req_rd tied 1 -> grant order 0,1,2,3,0,1,2,3 with vpi_req_valid continuously 1 for 8 cycles.
- Full/overflow: 5 pushes to ch1 with no pops (depth 4) -> dp_req_afull[1]=1 after the 3rd, dp_req_full[1]=1 after the 4th, 5th dropped, err_ovf[1]=1. Draining returns the 4 words in order.
- Response steering/underflow: vpi_rsp_wr with ch=3, data=0x12345678 -> dp_rsp_valid[3]=1 next cycle, others 0. dp_rsp_rd[0] while empty -> err_unf[0]=1, no state change.
- Reset mid-operation: 3 requests queued and output stage valid, pulse rst low -> everything empties immediately; following pushes behave as in the single-request test.

Source files
------------

// File: rtl/dp_vpi_bridge_mc.sv
// Multi-channel DP<->VPI bridge: per-channel FWFT request/response FIFOs,
// round-robin merge into one tagged VPI request stage, tag-steered responses.
module dp_vpi_bridge_mc #(
  parameter int NUM_CH     = 4,
  parameter int CH_BITS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 31,
  parameter int TID_WIDTH  = 16,
  parameter int REQ_AW     = 2,
  parameter int RSP_AW     = 2,
  parameter int AFULL_LVL  = 3,
  parameter int REQ_W      = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH,
  parameter int RSP_W      = TID_WIDTH + DATA_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_CH*REQ_W-1:0]   dp_req_data_i,
  input  logic [NUM_CH-1:0]         dp_req_wr_i,
  output logic [NUM_CH-1:0]         dp_req_full_o,
  output logic [NUM_CH-1:0]         dp_req_afull_o,
  output logic [REQ_W-1:0]          vpi_req_data_o,
  output logic [CH_BITS-1:0]        vpi_req_ch_o,
  output logic                      vpi_req_valid_o,
  input  logic                      vpi_req_rd_i,
  input  logic [RSP_W-1:0]          vpi_rsp_data_i,
  input  logic [CH_BITS-1:0]        vpi_rsp_ch_i,
  input  logic                      vpi_rsp_wr_i,
  output logic [NUM_CH-1:0]         vpi_rsp_full_o,
  output logic [NUM_CH*RSP_W-1:0]   dp_rsp_data_o,
  output logic [NUM_CH-1:0]         dp_rsp_valid_o,
  input  logic [NUM_CH-1:0]         dp_rsp_rd_i,
  output logic [2*NUM_CH-1:0]       err_ovf_o,
  output logic [NUM_CH:0]           err_unf_o
);

  localparam int REQ_DEPTH = 1 << REQ_AW;
  localparam int RSP_DEPTH = 1 << RSP_AW;
  localparam logic [REQ_AW:0] REQ_FULL_CNT  = (REQ_AW+1)'(REQ_DEPTH);
  localparam logic [REQ_AW:0] REQ_AFULL_CNT = (REQ_AW+1)'(AFULL_LVL);
  localparam logic [RSP_AW:0] RSP_FULL_CNT  = (RSP_AW+1)'(RSP_DEPTH);

  logic [NUM_CH-1:0] req_empty, req_pop, req_ovf_set;
  logic [REQ_W-1:0]  req_head [NUM_CH];
  logic [NUM_CH-1:0] rsp_ovf_set, rsp_unf_set;

  logic                load;
  logic                gnt_found;
  logic [CH_BITS-1:0]  gnt_ch, arb_idx;
  logic                out_valid_q;
  logic [REQ_W-1:0]    out_data_q;
  logic [CH_BITS-1:0]  out_ch_q, last_grant_q;
  logic [2*NUM_CH-1:0] err_ovf_q;
  logic [NUM_CH:0]     err_unf_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [REQ_AW-1:0] req_wp_q, req_rp_q;
    logic [REQ_AW:0]   req_cnt_q, req_cnt_d;
    logic [REQ_W-1:0]  req_mem_q [REQ_DEPTH];
    logic              req_full, req_push;
    logic [RSP_AW-1:0] rsp_wp_q, rsp_rp_q;
    logic [RSP_AW:0]   rsp_cnt_q, rsp_cnt_d;
    logic [RSP_W-1:0]  rsp_mem_q [RSP_DEPTH];
    logic              rsp_full, rsp_empty, rsp_push, rsp_pop, rsp_wr_sel;

    // Full is judged on registered count only, so a same-cycle pop never rescues a push.
    assign req_full         = (req_cnt_q == REQ_FULL_CNT);
    assign req_empty[c]     = (req_cnt_q == '0);
    assign req_push         = dp_req_wr_i[c] && !req_full;
    assign req_ovf_set[c]   = dp_req_wr_i[c] && req_full;
    assign req_head[c]      = req_mem_q[req_rp_q];
    assign dp_req_full_o[c]  = req_full;
    assign dp_req_afull_o[c] = (req_cnt_q >= REQ_AFULL_CNT);

    always_comb begin
      req_cnt_d = req_cnt_q;
      if (req_push && !req_pop[c])      req_cnt_d = req_cnt_q + (REQ_AW+1)'(1);
      else if (!req_push && req_pop[c]) req_cnt_d = req_cnt_q - (REQ_AW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        req_wp_q  <= '0;
        req_rp_q  <= '0;
        req_cnt_q <= '0;
      end else begin
        if (req_push)   req_wp_q <= req_wp_q + REQ_AW'(1);
        if (req_pop[c]) req_rp_q <= req_rp_q + REQ_AW'(1);
        req_cnt_q <= req_cnt_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (req_push) req_mem_q[req_wp_q] <= dp_req_data_i[c*REQ_W +: REQ_W];
    end

    assign rsp_wr_sel        = vpi_rsp_wr_i && (vpi_rsp_ch_i == CH_BITS'(c));
    assign rsp_full          = (rsp_cnt_q == RSP_FULL_CNT);
    assign rsp_empty         = (rsp_cnt_q == '0);
    assign rsp_push          = rsp_wr_sel && !rsp_full;
    assign rsp_pop           = dp_rsp_rd_i[c] && !rsp_empty;
    assign rsp_ovf_set[c]    = rsp_wr_sel && rsp_full;
    assign rsp_unf_set[c]    = dp_rsp_rd_i[c] && rsp_empty;
    assign vpi_rsp_full_o[c] = rsp_full;
    assign dp_rsp_valid_o[c] = !rsp_empty;
    // Memory is not reset, so the head is masked to keep the bus at zero when empty.
    assign dp_rsp_data_o[c*RSP_W +: RSP_W] = rsp_empty ? '0 : rsp_mem_q[rsp_rp_q];

    always_comb begin
      rsp_cnt_d = rsp_cnt_q;
      if (rsp_push && !rsp_pop)      rsp_cnt_d = rsp_cnt_q + (RSP_AW+1)'(1);
      else if (!rsp_push && rsp_pop) rsp_cnt_d = rsp_cnt_q - (RSP_AW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rsp_wp_q  <= '0;
        rsp_rp_q  <= '0;
        rsp_cnt_q <= '0;
      end else begin
        if (rsp_push) rsp_wp_q <= rsp_wp_q + RSP_AW'(1);
        if (rsp_pop)  rsp_rp_q <= rsp_rp_q + RSP_AW'(1);
        rsp_cnt_q <= rsp_cnt_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rsp_push) rsp_mem_q[rsp_wp_q] <= vpi_rsp_data_i;
    end
  end

  // Round-robin search starts one past the last granted channel.
  always_comb begin
    load      = !out_valid_q || vpi_req_rd_i;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    arb_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      arb_idx = last_grant_q + CH_BITS'(k);
      if (!gnt_found && !req_empty[arb_idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = arb_idx;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      req_pop[c] = load && gnt_found && (gnt_ch == CH_BITS'(c));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      last_grant_q <= CH_BITS'(NUM_CH - 1);
    end else if (load) begin
      if (gnt_found) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= req_head[gnt_ch];
        out_ch_q     <= gnt_ch;
        last_grant_q <= gnt_ch;
      end else begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_ovf_q <= '0;
      err_unf_q <= '0;
    end else begin
      err_ovf_q <= err_ovf_q | {rsp_ovf_set, req_ovf_set};
      err_unf_q <= err_unf_q | {vpi_req_rd_i && !out_valid_q, rsp_unf_set};
    end
  end

  assign vpi_req_valid_o = out_valid_q;
  assign vpi_req_data_o  = out_data_q;
  assign vpi_req_ch_o    = out_ch_q;
  assign err_ovf_o       = err_ovf_q;
  assign err_unf_o       = err_unf_q;

endmodule
